id_ex_reg: RTL and testbench

//  ID/EX pipeline register of the 5-stage MIPS core. Captures the control word from the

---
 rtl/id_ex_reg.sv | 142 ++++++++++++++
 tb/tb_id_ex_reg.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures the control word and decoded operands for the EX stage,
// with stall (hold), flush (bubble injection) and a saturating count of loaded bubbles.
module id_ex_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  reg_dst,
  input  logic                  branch,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_to_reg,
  input  logic                  alu_src,
  input  logic                  reg_write,
  input  logic                  jump,
  input  logic [1:0]            alu_op,
  input  logic [DATA_W-1:0]     pc_plus4,
  input  logic [DATA_W-1:0]     rd_data1,
  input  logic [DATA_W-1:0]     rd_data2,
  input  logic [DATA_W-1:0]     imm_ext,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  bubble_cnt_clr,
  output logic                  ex_reg_dst,
  output logic                  ex_branch,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_alu_src,
  output logic                  ex_reg_write,
  output logic                  ex_jump,
  output logic [1:0]            ex_alu_op,
  output logic [DATA_W-1:0]     ex_pc_plus4,
  output logic [DATA_W-1:0]     ex_rd_data1,
  output logic [DATA_W-1:0]     ex_rd_data2,
  output logic [DATA_W-1:0]     ex_imm_ext,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_valid,
  output logic [CNT_W-1:0]      bubble_cnt
);

  typedef struct packed {
    logic                  valid;
    logic                  reg_dst;
    logic                  branch;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  alu_src;
    logic                  reg_write;
    logic                  jump;
    logic [1:0]            alu_op;
    logic [DATA_W-1:0]     pc_plus4;
    logic [DATA_W-1:0]     rd_data1;
    logic [DATA_W-1:0]     rd_data2;
    logic [DATA_W-1:0]     imm_ext;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
  } word_t;

  word_t            id_word;
  word_t            bubble_word;
  word_t            ex_q;
  logic             bubble_load;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    bubble_word        = '0;
    bubble_word.alu_op = 2'b11;

    id_word            = '0;
    id_word.valid      = 1'b1;
    id_word.reg_dst    = reg_dst;
    id_word.branch     = branch;
    id_word.mem_read   = mem_read;
    id_word.mem_write  = mem_write;
    id_word.mem_to_reg = mem_to_reg;
    id_word.alu_src    = alu_src;
    id_word.reg_write  = reg_write;
    id_word.jump       = jump;
    id_word.alu_op     = alu_op;
    id_word.pc_plus4   = pc_plus4;
    id_word.rd_data1   = rd_data1;
    id_word.rd_data2   = rd_data2;
    id_word.imm_ext    = imm_ext;
    id_word.rs         = rs;
    id_word.rt         = rt;
    id_word.rd         = rd;
  end

  // Flush overrides stall; an invalid ID slot is discarded rather than held.
  assign bubble_load = flush | (~stall & ~id_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= bubble_word;
    end else if (bubble_load) begin
      ex_q <= bubble_word;
    end else if (!stall) begin
      ex_q <= id_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bubble_cnt_clr) begin
      cnt_q <= '0;
    end else if (bubble_load && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_branch     = ex_q.branch;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_jump       = ex_q.jump;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_pc_plus4   = ex_q.pc_plus4;
  assign ex_rd_data1   = ex_q.rd_data1;
  assign ex_rd_data2   = ex_q.rd_data2;
  assign ex_imm_ext    = ex_q.imm_ext;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_rd         = ex_q.rd;
  assign bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, load, stall, flush, hazard bubble and counter saturation.
module tb_id_ex_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, stall, flush;
  logic          reg_dst, branch, mem_read, mem_write, mem_to_reg, alu_src, reg_write, jump;
  logic [1:0]    alu_op;
  logic [DW-1:0] pc_plus4, rd_data1, rd_data2, imm_ext;
  logic [AW-1:0] rs, rt, rd;
  logic          bubble_cnt_clr;
  logic          ex_reg_dst, ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic          ex_alu_src, ex_reg_write, ex_jump, ex_valid;
  logic [1:0]    ex_alu_op;
  logic [DW-1:0] ex_pc_plus4, ex_rd_data1, ex_rd_data2, ex_imm_ext;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [CW-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .stall(stall), .flush(flush),
    .reg_dst(reg_dst), .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .reg_write(reg_write), .jump(jump),
    .alu_op(alu_op), .pc_plus4(pc_plus4), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .imm_ext(imm_ext), .rs(rs), .rt(rt), .rd(rd), .bubble_cnt_clr(bubble_cnt_clr),
    .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .ex_jump(ex_jump), .ex_alu_op(ex_alu_op),
    .ex_pc_plus4(ex_pc_plus4), .ex_rd_data1(ex_rd_data1), .ex_rd_data2(ex_rd_data2),
    .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Concatenation of every 1-bit control plus ex_valid: {valid,reg_dst,...,jump}
  function automatic logic [8:0] ctl();
    return {ex_valid, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg,
            ex_alu_src, ex_reg_write, ex_jump};
  endfunction

  task automatic chk_bubble(input string tag);
    chk({tag, "_ctl"}, 64'(ctl()), 64'h0);
    chk({tag, "_aluop"}, 64'(ex_alu_op), 64'h3);
    chk({tag, "_data"}, {ex_pc_plus4 | ex_rd_data1, ex_rd_data2 | ex_imm_ext}, 64'h0);
    chk({tag, "_addr"}, 64'({ex_rs, ex_rt, ex_rd}), 64'h0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; id_valid = 1'b0; stall = 1'b0; flush = 1'b0; bubble_cnt_clr = 1'b0;
    reg_dst = 0; branch = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0; alu_src = 0;
    reg_write = 0; jump = 0; alu_op = 2'b00;
    pc_plus4 = '0; rd_data1 = '0; rd_data2 = '0; imm_ext = '0; rs = '0; rt = '0; rd = '0;

    // 1: asynchronous reset mid-cycle, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk_bubble("reset");
    chk("reset_cnt", 64'(bubble_cnt), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2: load a full instruction
    id_valid = 1'b1; reg_write = 1'b1; alu_op = 2'b10; rd = 5'd9; rd_data1 = 32'hDEADBEEF;
    reg_dst = 1'b1; alu_src = 1'b1; pc_plus4 = 32'h0000_0104; rd_data2 = 32'h0000_00A5;
    imm_ext = 32'hFFFF_FFF0; rs = 5'd1; rt = 5'd2;
    cycle();
    chk("load_ctl", 64'(ctl()), 64'b1_1000_0110);
    chk("load_aluop", 64'(ex_alu_op), 64'h2);
    chk("load_rd", 64'(ex_rd), 64'd9);
    chk("load_rd1", 64'(ex_rd_data1), 64'hDEADBEEF);
    chk("load_pc_rd2", {ex_pc_plus4, ex_rd_data2}, 64'h0000_0104_0000_00A5);
    chk("load_imm", 64'(ex_imm_ext), 64'hFFFF_FFF0);
    chk("load_rs_rt", 64'({ex_rs, ex_rt}), 64'({5'd1, 5'd2}));
    chk("load_cnt", 64'(bubble_cnt), 64'h0);

    // 3: stall three cycles with changing inputs
    stall = 1'b1; rd = 5'd3; rd_data1 = 32'h0; alu_op = 2'b01; reg_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_rd", 64'(ex_rd), 64'd9);
      chk("stall_rd1", 64'(ex_rd_data1), 64'hDEADBEEF);
      chk("stall_cnt", 64'(bubble_cnt), 64'h0);
    end
    chk("stall_valid", 64'(ex_valid), 64'h1);

    // 4: flush overrides stall
    flush = 1'b1;
    cycle();
    chk_bubble("flush_over_stall");
    chk("flush_cnt", 64'(bubble_cnt), 64'h1);

    // 5: hazard bubble from id_valid=0 discards live-looking inputs
    flush = 1'b0; stall = 1'b0; id_valid = 1'b0; reg_write = 1'b1; rd_data2 = 32'h1234;
    cycle();
    chk("hazard_regwrite", 64'(ex_reg_write), 64'h0);
    chk("hazard_rd2", 64'(ex_rd_data2), 64'h0);
    chk("hazard_aluop", 64'(ex_alu_op), 64'h3);
    chk("hazard_valid", 64'(ex_valid), 64'h0);
    chk("hazard_cnt", 64'(bubble_cnt), 64'h2);

    // Stall over an existing bubble holds it and does not count
    id_valid = 1'b1; stall = 1'b1;
    cycle();
    chk("stall_bubble_valid", 64'(ex_valid), 64'h0);
    chk("stall_bubble_cnt", 64'(bubble_cnt), 64'h2);

    // Reset asserted mid-stall after a real load
    stall = 1'b0;
    cycle();
    chk("reload_rd", 64'(ex_rd), 64'd3);
    chk("reload_rd2", 64'(ex_rd_data2), 64'h1234);
    stall = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_bubble("reset_mid_stall");
    chk("reset_mid_stall_cnt", 64'(bubble_cnt), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("post_reset_stall_valid", 64'(ex_valid), 64'h0);
    stall = 1'b0;
    cycle();
    chk("post_reset_load_valid", 64'(ex_valid), 64'h1);
    chk("post_reset_load_rd", 64'(ex_rd), 64'd3);

    // 6: saturation with CNT_W=4
    flush = 1'b1;
    for (int i = 0; i < 14; i++) cycle();
    chk("cnt_14", 64'(bubble_cnt), 64'hE);
    cycle();
    chk("cnt_15", 64'(bubble_cnt), 64'hF);
    for (int i = 0; i < 5; i++) cycle();
    chk("cnt_sat", 64'(bubble_cnt), 64'hF);
    bubble_cnt_clr = 1'b1;
    cycle();
    chk("cnt_clr_wins", 64'(bubble_cnt), 64'h0);
    bubble_cnt_clr = 1'b0;
    cycle();
    chk("cnt_after_clr", 64'(bubble_cnt), 64'h1);
    flush = 1'b0; id_valid = 1'b1;
    cycle();
    chk("cnt_on_load", 64'(bubble_cnt), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
